// File: rtl/floppy_pkg.sv
// Shared constants and types for the floppy read-path byte stream.
// CRC presets are the CCITT state after the A1 A1 A1 sync plus the address mark.
package floppy_pkg;

    localparam logic [7:0]  GAP_BYTE_DEF    = 8'h4E;
    localparam logic [15:0] CRC_PRESET_ID   = 16'hB230;
    localparam logic [15:0] CRC_PRESET_DATA = 16'hE295;
    localparam logic [15:0] CRC_POLY        = 16'h1021;

    localparam logic [1:0] TYPE_GAP  = 2'd0;
    localparam logic [1:0] TYPE_ID   = 2'd1;
    localparam logic [1:0] TYPE_DATA = 2'd2;
    localparam logic [1:0] TYPE_CRC  = 2'd3;

    typedef enum logic [1:0] {
        PH_GAP  = 2'd0,
        PH_HDR  = 2'd1,
        PH_DATA = 2'd2
    } phase_e;

endpackage

// File: rtl/floppy_crc16.sv
// Byte-wise CCITT CRC-16 step, MSB first, fully combinational.
module floppy_crc16
    import floppy_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [7:0]  byte_i,
    output logic [15:0] crc_o
);

    logic [15:0] c;

    always_comb begin
        c = crc_i;
        for (int i = 7; i >= 0; i--) begin
            c = {c[14:0], 1'b0} ^ ((c[15] ^ byte_i[i]) ? CRC_POLY : 16'h0000);
        end
        crc_o = c;
    end

endmodule

// File: rtl/floppy_byte_stream.sv
// Converts drive phase timing into the FDC byte stream: ID field, buffered sector
// data, data CRC and gap filler, one registered byte per dclk_en slot.
module floppy_byte_stream
    import floppy_pkg::*;
#(
    parameter logic [7:0] GAP_BYTE = GAP_BYTE_DEF,
    parameter int         BUF_AW   = 10
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              dclk_en_i,
    input  logic              ready_i,
    input  logic              sector_hdr_i,
    input  logic              sector_data_i,
    input  logic [6:0]        track_i,
    input  logic              side_i,
    input  logic [5:0]        sector_i,
    input  logic [1:0]        sector_size_code_i,
    output logic [BUF_AW-1:0] buf_addr_o,
    output logic              buf_rd_o,
    input  logic [7:0]        buf_rdata_i,
    output logic [7:0]        dout_o,
    output logic              dout_strobe_o,
    output logic [1:0]        dout_type_o,
    output logic              id_mark_o,
    output logic              data_mark_o
);

    phase_e            phase_q, phase_d, ph_in;
    logic [9:0]        idx_q, idx_d, idx_cur;
    logic              entry;
    logic [15:0]       crc_q, crc_d, crc_base, crc_next;
    logic [7:0]        crc_byte, data_byte, hold_q, hold_d;
    logic [1:0]        crc_pend_q, crc_pend_d, pend_cur;
    logic              rd_vld_q;
    logic [7:0]        dout_q, dout_d;
    logic [1:0]        type_q, type_d;
    logic              strobe_q, strobe_d, id_mark_q, id_mark_d, data_mark_q, data_mark_d;
    logic              buf_rd_q, buf_rd_d;
    logic [BUF_AW-1:0] buf_addr_q, buf_addr_d;

    floppy_crc16 u_crc (
        .crc_i  (crc_base),
        .byte_i (crc_byte),
        .crc_o  (crc_next)
    );

    // Read data arriving in the same clk as dclk_en is used directly, else the holding copy.
    always_comb begin
        ph_in     = sector_hdr_i ? PH_HDR : (sector_data_i ? PH_DATA : PH_GAP);
        entry     = (ph_in != phase_q);
        idx_cur   = entry ? 10'd0 : idx_q + 10'd1;
        data_byte = rd_vld_q ? buf_rdata_i : hold_q;
        pend_cur  = (entry && phase_q == PH_DATA) ? 2'd2 : crc_pend_q;
        crc_base  = crc_q;
        crc_byte  = data_byte;
        case (ph_in)
            PH_HDR: begin
                if (entry) crc_base = CRC_PRESET_ID;
                case (idx_cur)
                    10'd0:   crc_byte = {1'b0, track_i};
                    10'd1:   crc_byte = {7'b0, side_i};
                    10'd2:   crc_byte = {2'b0, sector_i};
                    10'd3:   crc_byte = {6'b0, sector_size_code_i};
                    default: crc_byte = 8'h00;
                endcase
            end
            PH_DATA: if (entry) crc_base = CRC_PRESET_DATA;
            default: ;
        endcase
    end

    always_comb begin
        phase_d     = phase_q;
        idx_d       = idx_q;
        crc_d       = crc_q;
        crc_pend_d  = crc_pend_q;
        hold_d      = rd_vld_q ? buf_rdata_i : hold_q;
        dout_d      = dout_q;
        type_d      = type_q;
        strobe_d    = 1'b0;
        id_mark_d   = 1'b0;
        data_mark_d = 1'b0;
        buf_rd_d    = 1'b0;
        buf_addr_d  = buf_addr_q;
        if (dclk_en_i) begin
            phase_d  = ph_in;
            idx_d    = idx_cur;
            strobe_d = ready_i;
            case (ph_in)
                PH_HDR: begin
                    crc_pend_d = 2'd0;
                    id_mark_d  = entry && ready_i;
                    if (idx_cur <= 10'd3) begin
                        dout_d = crc_byte;
                        type_d = TYPE_ID;
                        crc_d  = crc_next;
                    end else if (idx_cur == 10'd4) begin
                        dout_d = crc_base[15:8];
                        type_d = TYPE_CRC;
                    end else if (idx_cur == 10'd5) begin
                        dout_d     = crc_base[7:0];
                        type_d     = TYPE_CRC;
                        buf_addr_d = '0;
                        buf_rd_d   = ready_i;
                    end else begin
                        dout_d = GAP_BYTE;
                        type_d = TYPE_GAP;
                    end
                end
                PH_DATA: begin
                    crc_pend_d  = 2'd0;
                    data_mark_d = entry && ready_i;
                    dout_d      = data_byte;
                    type_d      = TYPE_DATA;
                    crc_d       = crc_next;
                    buf_addr_d  = BUF_AW'(idx_cur + 10'd1);
                    buf_rd_d    = ready_i;
                end
                default: begin
                    type_d = TYPE_CRC;
                    case (pend_cur)
                        2'd2: begin
                            dout_d     = crc_q[15:8];
                            crc_pend_d = 2'd1;
                        end
                        2'd1: begin
                            dout_d     = crc_q[7:0];
                            crc_pend_d = 2'd0;
                        end
                        default: begin
                            dout_d     = GAP_BYTE;
                            type_d     = TYPE_GAP;
                            crc_pend_d = 2'd0;
                        end
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            phase_q     <= PH_GAP;
            idx_q       <= '0;
            crc_q       <= 16'hFFFF;
            crc_pend_q  <= '0;
            hold_q      <= '0;
            rd_vld_q    <= 1'b0;
            dout_q      <= '0;
            type_q      <= TYPE_GAP;
            strobe_q    <= 1'b0;
            id_mark_q   <= 1'b0;
            data_mark_q <= 1'b0;
            buf_rd_q    <= 1'b0;
            buf_addr_q  <= '0;
        end else begin
            phase_q     <= phase_d;
            idx_q       <= idx_d;
            crc_q       <= crc_d;
            crc_pend_q  <= crc_pend_d;
            hold_q      <= hold_d;
            rd_vld_q    <= buf_rd_q;
            dout_q      <= dout_d;
            type_q      <= type_d;
            strobe_q    <= strobe_d;
            id_mark_q   <= id_mark_d;
            data_mark_q <= data_mark_d;
            buf_rd_q    <= buf_rd_d;
            buf_addr_q  <= buf_addr_d;
        end
    end

    assign dout_o        = dout_q;
    assign dout_strobe_o = strobe_q;
    assign dout_type_o   = type_q;
    assign id_mark_o     = id_mark_q;
    assign data_mark_o   = data_mark_q;
    assign buf_rd_o      = buf_rd_q;
    assign buf_addr_o    = buf_addr_q;

endmodule

// File: tb/tb_floppy_byte_stream.sv
// Directed bench for floppy_byte_stream: captured output bytes are compared against
// hand-computed ID fields and a bit-serial reference CRC of the on-disk byte sequence.
module tb_floppy_byte_stream;

    logic       clk = 1'b0;
    logic       reset, dclk_en, ready, sector_hdr, sector_data;
    logic [6:0] track;
    logic       side;
    logic [5:0] sector;
    logic [1:0] size_code;
    logic [9:0] buf_addr;
    logic       buf_rd;
    logic [7:0] buf_rdata;
    logic [7:0] dout;
    logic       dout_strobe, id_mark, data_mark;
    logic [1:0] dout_type;

    logic [7:0]  mem [0:1023];
    logic [11:0] q [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          rd_cnt  = 0;
    int          exp_addr = 0;
    bit          addr_chk = 1'b0;
    int          rd_before;

    floppy_byte_stream dut (
        .clk_i              (clk),
        .reset_i            (reset),
        .dclk_en_i          (dclk_en),
        .ready_i            (ready),
        .sector_hdr_i       (sector_hdr),
        .sector_data_i      (sector_data),
        .track_i            (track),
        .side_i             (side),
        .sector_i           (sector),
        .sector_size_code_i (size_code),
        .buf_addr_o         (buf_addr),
        .buf_rd_o           (buf_rd),
        .buf_rdata_i        (buf_rdata),
        .dout_o             (dout),
        .dout_strobe_o      (dout_strobe),
        .dout_type_o        (dout_type),
        .id_mark_o          (id_mark),
        .data_mark_o        (data_mark)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) if (buf_rd) buf_rdata <= mem[buf_addr];

    always @(negedge clk) begin
        if (dout_strobe) q.push_back({data_mark, id_mark, dout_type, dout});
        if (buf_rd) begin
            rd_cnt++;
            if (addr_chk) begin
                chk("buf_addr sequence", {22'b0, buf_addr}, exp_addr);
                exp_addr++;
            end
        end
    end

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) r = (r[15] ^ b[i]) ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    task automatic slot(input logic h, input logic d);
        sector_hdr  = h;
        sector_data = d;
        dclk_en     = 1'b1;
        @(posedge clk); #1;
        dclk_en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_hdr(input logic [6:0] t, input logic s, input logic [5:0] sec, input logic [1:0] n);
        track = t; side = s; sector = sec; size_code = n;
        repeat (6) slot(1'b1, 1'b0);
    endtask

    task automatic run_data(input int n);
        repeat (n) slot(1'b0, 1'b1);
    endtask

    task automatic run_gap(input int n);
        repeat (n) slot(1'b0, 1'b0);
    endtask

    task automatic exp_byte(input string tag, input logic [7:0] d, input logic [1:0] t,
                            input logic idm, input logic dm);
        if (q.size() == 0) chk({tag, " byte present"}, 0, 1);
        else chk(tag, {20'b0, q.pop_front()}, {20'b0, dm, idm, t, d});
    endtask

    task automatic exp_hdr(input string tag, input logic [6:0] t, input logic s,
                           input logic [5:0] sec, input logic [1:0] n);
        logic [7:0]  b [4];
        logic [15:0] c;
        b[0] = {1'b0, t}; b[1] = {7'b0, s}; b[2] = {2'b0, sec}; b[3] = {6'b0, n};
        c = 16'hFFFF;
        c = crc_upd(c, 8'hA1); c = crc_upd(c, 8'hA1); c = crc_upd(c, 8'hA1); c = crc_upd(c, 8'hFE);
        for (int i = 0; i < 4; i++) begin
            exp_byte({tag, " id"}, b[i], 2'd1, i == 0, 1'b0);
            c = crc_upd(c, b[i]);
        end
        exp_byte({tag, " id crc hi"}, c[15:8], 2'd3, 1'b0, 1'b0);
        exp_byte({tag, " id crc lo"}, c[7:0], 2'd3, 1'b0, 1'b0);
    endtask

    // ncrc: CRC bytes the following gap produced (2 = both plus one filler, 1 = hi only)
    task automatic exp_data(input string tag, input int n, input int ncrc);
        logic [15:0] c;
        c = 16'hFFFF;
        c = crc_upd(c, 8'hA1); c = crc_upd(c, 8'hA1); c = crc_upd(c, 8'hA1); c = crc_upd(c, 8'hFB);
        for (int i = 0; i < n; i++) begin
            exp_byte({tag, " data"}, mem[i], 2'd2, 1'b0, i == 0);
            c = crc_upd(c, mem[i]);
        end
        exp_byte({tag, " data crc hi"}, c[15:8], 2'd3, 1'b0, 1'b0);
        if (ncrc == 2) begin
            exp_byte({tag, " data crc lo"}, c[7:0], 2'd3, 1'b0, 1'b0);
            exp_byte({tag, " gap after crc"}, 8'h4E, 2'd0, 1'b0, 1'b0);
        end
    endtask

    task automatic exp_std_id(input string tag);
        exp_byte({tag, " id0"}, 8'h00, 2'd1, 1'b1, 1'b0);
        exp_byte({tag, " id1"}, 8'h00, 2'd1, 1'b0, 1'b0);
        exp_byte({tag, " id2"}, 8'h01, 2'd1, 1'b0, 1'b0);
        exp_byte({tag, " id3"}, 8'h02, 2'd1, 1'b0, 1'b0);
        exp_byte({tag, " id4"}, 8'hCA, 2'd3, 1'b0, 1'b0);
        exp_byte({tag, " id5"}, 8'h6F, 2'd3, 1'b0, 1'b0);
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < 1024; i++) mem[i] = 8'((i * 37 + 11) & 8'hFF);
    endtask

    initial begin
        reset = 1'b1; dclk_en = 1'b0; ready = 1'b1; sector_hdr = 1'b0; sector_data = 1'b0;
        track = '0; side = 1'b0; sector = '0; size_code = '0; buf_rdata = '0;
        fill_pattern();
        repeat (3) @(posedge clk);
        #1;
        chk("reset dout", {24'b0, dout}, 0);
        chk("reset dout_strobe", {31'b0, dout_strobe}, 0);
        chk("reset dout_type", {30'b0, dout_type}, 0);
        chk("reset id_mark", {31'b0, id_mark}, 0);
        chk("reset data_mark", {31'b0, data_mark}, 0);
        chk("reset buf_rd", {31'b0, buf_rd}, 0);
        chk("reset buf_addr", {22'b0, buf_addr}, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 1 + 3: standard ID field, then a 512-byte sector with address tracking
        run_gap(2);
        exp_byte("t1 gap0", 8'h4E, 2'd0, 1'b0, 1'b0);
        exp_byte("t1 gap1", 8'h4E, 2'd0, 1'b0, 1'b0);
        addr_chk = 1'b1; exp_addr = 0; rd_cnt = 0;
        run_hdr(7'd0, 1'b0, 6'd1, 2'd2);
        run_data(512);
        run_gap(3);
        addr_chk = 1'b0;
        exp_std_id("t1");
        exp_data("t3", 512, 2);
        chk("t3 read count", rd_cnt, 513);
        chk("t3 queue drained", q.size(), 0);

        // 2: 128 zero bytes
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        run_hdr(7'd2, 1'b1, 6'd9, 2'd0);
        run_data(128);
        run_gap(3);
        exp_hdr("t2", 7'd2, 1'b1, 6'd9, 2'd0);
        exp_data("t2", 128, 2);
        chk("t2 queue drained", q.size(), 0);
        fill_pattern();

        // 6: single gap slot between data and next ID field
        run_hdr(7'd1, 1'b0, 6'd2, 2'd0);
        run_data(4);
        run_gap(1);
        run_hdr(7'd0, 1'b0, 6'd1, 2'd2);
        run_gap(1);
        exp_hdr("t6a", 7'd1, 1'b0, 6'd2, 2'd0);
        exp_data("t6", 4, 1);
        exp_std_id("t6b");
        exp_byte("t6 gap", 8'h4E, 2'd0, 1'b0, 1'b0);
        chk("t6 queue drained", q.size(), 0);

        // 4: ready dropped mid-data
        run_hdr(7'd3, 1'b0, 6'd4, 2'd1);
        run_data(10);
        exp_hdr("t4a", 7'd3, 1'b0, 6'd4, 2'd1);
        for (int i = 0; i < 10; i++) exp_byte("t4 data", mem[i], 2'd2, 1'b0, i == 0);
        ready = 1'b0;
        rd_before = rd_cnt;
        run_data(10);
        chk("t4 no strobe while not ready", q.size(), 0);
        chk("t4 no buf_rd while not ready", rd_cnt, rd_before);
        ready = 1'b1;
        run_data(10);
        run_gap(3);
        q.delete();
        run_hdr(7'd5, 1'b1, 6'd3, 2'd1);
        exp_hdr("t4b", 7'd5, 1'b1, 6'd3, 2'd1);
        chk("t4 queue drained", q.size(), 0);

        // 5: async reset at data byte 37
        run_hdr(7'd0, 1'b1, 6'd7, 2'd0);
        run_data(37);
        q.delete();
        sector_data = 1'b1; sector_hdr = 1'b0; dclk_en = 1'b1;
        @(posedge clk); #1;
        dclk_en = 1'b0;
        chk("t5 byte 37 strobe", {31'b0, dout_strobe}, 1);
        #2 reset = 1'b1;
        #1;
        chk("t5 reset dout", {24'b0, dout}, 0);
        chk("t5 reset strobe", {31'b0, dout_strobe}, 0);
        chk("t5 reset type", {30'b0, dout_type}, 0);
        chk("t5 reset buf_rd", {31'b0, buf_rd}, 0);
        chk("t5 reset buf_addr", {22'b0, buf_addr}, 0);
        sector_data = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        q.delete();
        run_gap(2);
        run_hdr(7'd0, 1'b1, 6'd7, 2'd0);
        run_data(128);
        run_gap(3);
        exp_byte("t5 gap0", 8'h4E, 2'd0, 1'b0, 1'b0);
        exp_byte("t5 gap1", 8'h4E, 2'd0, 1'b0, 1'b0);
        exp_hdr("t5", 7'd0, 1'b1, 6'd7, 2'd0);
        exp_data("t5", 128, 2);
        chk("t5 queue drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
